// File: rtl/system86_vid_capture.sv
// system86_vid_capture
//   Captures the System 86 native video bus in the clk_48m domain and turns
//   it into a FIFO-buffered pixel stream with x/y coordinates, plus per-frame
//   active-size measurement and a sticky overflow flag.
//
// Ports
//   clk_48m, rst_n            master clock, async active-low reset
//   enable                    capture enable, sampled at vsync falls
//   vid_clk, vid_data,        raw video bus; vid_clk is treated as data and
//   vid_*sync_n, vid_*blank_n edge-detected into a one-cycle strobe
//   pix_valid/ready/data/x/y  first-word-fall-through pixel stream
//   pix_sof, pix_sol          head is first pixel of frame / of line
//   frame_done                one-cycle pulse when h_active/v_active update
//   h_active, v_active        width of last line / line count of last frame
//   overflow, overflow_clr    sticky pixel-drop flag and its clear
module system86_vid_capture #(
    parameter int FIFO_DEPTH = 16,
    parameter int X_WIDTH    = 9,
    parameter int Y_WIDTH    = 9
) (
    input  logic               clk_48m,
    input  logic               rst_n,
    input  logic               enable,
    input  logic               vid_clk,
    input  logic [11:0]        vid_data,
    input  logic               vid_hsync_n,
    input  logic               vid_vsync_n,
    input  logic               vid_hblank_n,
    input  logic               vid_vblank_n,
    output logic               pix_valid,
    input  logic               pix_ready,
    output logic [11:0]        pix_data,
    output logic [X_WIDTH-1:0] pix_x,
    output logic [Y_WIDTH-1:0] pix_y,
    output logic               pix_sof,
    output logic               pix_sol,
    output logic               frame_done,
    output logic [X_WIDTH-1:0] h_active,
    output logic [Y_WIDTH-1:0] v_active,
    output logic               overflow,
    input  logic               overflow_clr
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef struct packed {
        logic [11:0]        data;
        logic [X_WIDTH-1:0] x;
        logic [Y_WIDTH-1:0] y;
        logic               sof;
        logic               sol;
    } pix_t;

    typedef enum logic [1:0] {IDLE, WAIT, ACTIVE} state_t;

    // Line boundaries come from hblank alone; hsync carries no extra information.
    logic unused_hsync;
    assign unused_hsync = vid_hsync_n;

    // ---------------- input stage ----------------
    logic        s1_clk, s2_clk, s1_vs_n, s1_hb_n, s1_vb_n, prev_vs_n;
    logic [11:0] s1_data;
    logic        strobe, vs_fall, active;

    always_ff @(posedge clk_48m or negedge rst_n) begin
        if (!rst_n) begin
            s1_clk    <= 1'b0;
            s2_clk    <= 1'b0;
            s1_data   <= '0;
            s1_vs_n   <= 1'b1;
            s1_hb_n   <= 1'b0;
            s1_vb_n   <= 1'b0;
            prev_vs_n <= 1'b1;
        end else begin
            s1_clk  <= vid_clk;
            s2_clk  <= s1_clk;
            s1_data <= vid_data;
            s1_vs_n <= vid_vsync_n;
            s1_hb_n <= vid_hblank_n;
            s1_vb_n <= vid_vblank_n;
            // vsync history only advances with the pixel clock so a fall is
            // seen exactly once per pixel period.
            if (strobe) prev_vs_n <= s1_vs_n;
        end
    end

    assign strobe  = s1_clk & ~s2_clk;
    assign vs_fall = strobe & ~s1_vs_n & prev_vs_n;
    assign active  = s1_hb_n & s1_vb_n;

    // ---------------- FSM ----------------
    state_t state, state_nxt;
    logic   clr, proc, fend;

    always_ff @(posedge clk_48m or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        clr       = 1'b0;
        proc      = 1'b0;
        fend      = 1'b0;
        if (strobe) begin
            case (state)
                IDLE: if (vs_fall && enable) begin
                    clr       = 1'b1;
                    state_nxt = WAIT;
                end
                WAIT: if (active) begin
                    proc      = 1'b1;
                    state_nxt = ACTIVE;
                end
                ACTIVE: begin
                    proc = 1'b1;
                    if (vs_fall) begin
                        fend      = 1'b1;
                        clr       = enable;
                        state_nxt = enable ? WAIT : IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // ---------------- coordinate counters / measurement ----------------
    logic [X_WIDTH-1:0] x, x_inc, last_w;
    logic [Y_WIDTH-1:0] y, y_inc, lines, lines_inc;
    logic               line_has_px, push, line_end;

    assign push      = proc & active;
    assign line_end  = proc & ~active & line_has_px;
    assign x_inc     = (&x)     ? x     : x + X_WIDTH'(1);
    assign y_inc     = (&y)     ? y     : y + Y_WIDTH'(1);
    assign lines_inc = (&lines) ? lines : lines + Y_WIDTH'(1);

    always_ff @(posedge clk_48m or negedge rst_n) begin
        if (!rst_n) begin
            x           <= '0;
            y           <= '0;
            lines       <= '0;
            last_w      <= '0;
            line_has_px <= 1'b0;
            h_active    <= '0;
            v_active    <= '0;
            frame_done  <= 1'b0;
        end else begin
            frame_done <= fend;
            if (push) begin
                x           <= x_inc;
                line_has_px <= 1'b1;
            end
            if (line_end) begin
                last_w      <= x;
                y           <= y_inc;
                lines       <= lines_inc;
                x           <= '0;
                line_has_px <= 1'b0;
            end
            // A line end in the same strobe is folded in before publishing.
            if (fend) begin
                h_active <= line_end ? x : last_w;
                v_active <= line_end ? lines_inc : lines;
            end
            if (clr) begin
                x           <= '0;
                y           <= '0;
                lines       <= '0;
                line_has_px <= 1'b0;
            end
        end
    end

    // ---------------- pixel FIFO ----------------
    pix_t          mem [FIFO_DEPTH];
    pix_t          entry, head;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          full, wr, pop;

    assign entry = '{data: s1_data, x: x, y: y,
                     sof: (x == '0) && (y == '0), sol: (x == '0)};
    // Full is judged before any same-cycle pop: a pop never makes room for
    // the push happening alongside it.
    assign full = (count == (AW+1)'(FIFO_DEPTH));
    assign wr   = push & ~full;
    assign pop  = pix_valid & pix_ready;

    always_ff @(posedge clk_48m) begin
        if (wr) mem[wr_ptr] <= entry;
    end

    always_ff @(posedge clk_48m or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr)  wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            case ({wr, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: ;
            endcase
            if (push && full)      overflow <= 1'b1;
            else if (overflow_clr) overflow <= 1'b0;
        end
    end

    // Head fields are forced to zero while empty so reset state is clean
    // without having to reset the storage array.
    assign head      = mem[rd_ptr];
    assign pix_valid = (count != '0);
    assign pix_data  = pix_valid ? head.data : '0;
    assign pix_x     = pix_valid ? head.x    : '0;
    assign pix_y     = pix_valid ? head.y    : '0;
    assign pix_sof   = pix_valid & head.sof;
    assign pix_sol   = pix_valid & head.sol;

endmodule

// File: tb/tb_system86_vid_capture.sv
// Directed bench for system86_vid_capture. The video driver knows the frame
// geometry and which frames should be captured, so it fills an expected-pixel
// queue directly from loop indices; a compare process checks every accepted
// pixel and every frame_done pulse against that model.
module tb_system86_vid_capture;
    localparam int XW  = 9;
    localparam int YW  = 9;
    localparam int BIG = 1000000;

    logic          clk = 1'b0, rst_n = 1'b0, enable = 1'b0;
    logic          vid_clk = 1'b0, hs_n = 1'b1, vs_n = 1'b1, hb_n = 1'b0, vb_n = 1'b0;
    logic [11:0]   vid_data = '0;
    logic          pix_ready = 1'b0, overflow_clr = 1'b0;
    logic          pix_valid, pix_sof, pix_sol, frame_done, overflow;
    logic [11:0]   pix_data;
    logic [XW-1:0] pix_x, h_active;
    logic [YW-1:0] pix_y, v_active;

    system86_vid_capture #(.FIFO_DEPTH(16), .X_WIDTH(XW), .Y_WIDTH(YW)) dut (
        .clk_48m(clk), .rst_n(rst_n), .enable(enable), .vid_clk(vid_clk),
        .vid_data(vid_data), .vid_hsync_n(hs_n), .vid_vsync_n(vs_n),
        .vid_hblank_n(hb_n), .vid_vblank_n(vb_n), .pix_valid(pix_valid),
        .pix_ready(pix_ready), .pix_data(pix_data), .pix_x(pix_x), .pix_y(pix_y),
        .pix_sof(pix_sof), .pix_sol(pix_sol), .frame_done(frame_done),
        .h_active(h_active), .v_active(v_active), .overflow(overflow),
        .overflow_clr(overflow_clr));

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] d;
        int          x;
        int          y;
        bit          sof;
        bit          sol;
    } exp_t;

    exp_t q[$];
    int   checks = 0, passes = 0;
    int   rx = 0, fd_cnt = 0, exp_h = 0, exp_v = 0, ready_mode = 0;
    int   first_x, first_y, last_x, last_y;
    bit   first_sof, prev_fd = 1'b0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // pix_ready: 0 = held low, 1 = held high, 2 = toggles every cycle
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       pix_ready = 1'b0;
            1:       pix_ready = 1'b1;
            default: pix_ready = ~pix_ready;
        endcase
    end

    // Compare process: sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (pix_valid && pix_ready) begin
                if (q.size() == 0) chk("extra_pixel", 1, 0);
                else begin
                    e = q.pop_front();
                    chk("pixel", longint'({pix_data, pix_x, pix_y, pix_sof, pix_sol}),
                        longint'({e.d, XW'(e.x), YW'(e.y), e.sof, e.sol}));
                end
                if (rx == 0) begin
                    first_x = int'(pix_x); first_y = int'(pix_y); first_sof = pix_sof;
                end
                last_x = int'(pix_x);
                last_y = int'(pix_y);
                rx++;
            end
            if (frame_done) begin
                fd_cnt++;
                chk("frame_h_active", h_active, exp_h);
                chk("frame_v_active", v_active, exp_v);
                chk("frame_done_width", prev_fd, 0);
            end
            prev_fd = frame_done;
        end
    end

    // One pixel period of vid_clk = 4 clk cycles (2 low, 2 high).
    task automatic pix_clk();
        vid_clk = 1'b0;
        repeat (2) @(posedge clk);
        #1 vid_clk = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Drives one frame: vb blank lines (vsync low briefly at line 0 when vs),
    // then h active lines of w pixels followed by hb blank pixels. When cap,
    // up to keep active pixels are expected at the output.
    task automatic send_frame(input int w, input int h, input int hb, input int vb,
                              input bit cap, input int keep, input int en_line,
                              input bit en_val, input bit vs, input int tag);
        int pushed = 0;
        for (int ln = 0; ln < vb + h; ln++) begin
            if (ln == en_line) enable = en_val;
            for (int px = 0; px < w + hb; px++) begin
                vs_n     = !(vs && ln == 0 && px < 2);
                vb_n     = (ln >= vb);
                hb_n     = (px < w);
                hs_n     = !(px == w + 1);
                vid_data = 12'(ln * 37 + px * 5 + tag * 101);
                if (cap && hb_n && vb_n && pushed < keep) begin
                    exp_t e;
                    e.d   = vid_data;
                    e.x   = (px > 511) ? 511 : px;
                    e.y   = ln - vb;
                    e.sof = (e.x == 0 && e.y == 0);
                    e.sol = (e.x == 0);
                    q.push_back(e);
                    pushed++;
                end
                pix_clk();
            end
        end
    endtask

    task automatic vsync_line();
        send_frame(4, 0, 4, 1, 1'b0, 0, -1, 1'b0, 1'b1, 0);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((q.size() != 0 || pix_valid) && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        chk({name, "_drain_timeout"}, n < 3000, 1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int fd0;
        // ---- reset state ----
        repeat (3) @(posedge clk);
        #1;
        chk("reset_pix_valid", pix_valid, 0);
        chk("reset_frame_done", frame_done, 0);
        chk("reset_overflow", overflow, 0);
        chk("reset_h_active", h_active, 0);
        chk("reset_v_active", v_active, 0);
        chk("reset_pix_bus", longint'({pix_data, pix_x, pix_y, pix_sof, pix_sol}), 0);
        rst_n = 1'b1;

        // ---- basic frame 16x6, ready high ----
        enable = 1'b1; ready_mode = 1; exp_h = 16; exp_v = 6; rx = 0; fd0 = fd_cnt;
        send_frame(16, 6, 4, 2, 1'b1, BIG, -1, 1'b1, 1'b1, 1);
        vsync_line();
        drain("basic");
        chk("basic_count", rx, 96);
        chk("basic_last_x", last_x, 15);
        chk("basic_last_y", last_y, 5);
        chk("basic_frame_done", fd_cnt - fd0, 1);
        chk("basic_overflow", overflow, 0);

        // ---- x saturation: 520-pixel line ----
        exp_h = 511; exp_v = 1; rx = 0; fd0 = fd_cnt;
        send_frame(520, 1, 4, 1, 1'b1, BIG, -1, 1'b1, 1'b1, 2);
        vsync_line();
        drain("sat");
        chk("sat_count", rx, 520);
        chk("sat_last_x", last_x, 511);
        chk("sat_frame_done", fd_cnt - fd0, 1);

        // ---- overflow with ready low ----
        ready_mode = 0;
        repeat (3) @(posedge clk);
        #1;
        exp_h = 8; exp_v = 4; rx = 0; fd0 = fd_cnt;
        send_frame(8, 4, 2, 2, 1'b1, 16, -1, 1'b1, 1'b1, 3);
        enable = 1'b0;
        vsync_line();
        chk("ovf_set", overflow, 1);
        chk("ovf_valid", pix_valid, 1);
        chk("ovf_frame_done", fd_cnt - fd0, 1);
        ready_mode = 1;
        drain("ovf");
        chk("ovf_count", rx, 16);
        chk("ovf_first_sof", first_sof, 1);
        chk("ovf_last_xy", last_x * 100 + last_y, 701);
        chk("ovf_still_set", overflow, 1);
        overflow_clr = 1'b1;
        @(posedge clk); #1;
        overflow_clr = 1'b0;
        chk("ovf_cleared", overflow, 0);

        // ---- capture enabled mid-frame ----
        exp_h = 8; exp_v = 4; rx = 0; fd0 = fd_cnt;
        send_frame(8, 4, 2, 2, 1'b0, 0, 3, 1'b1, 1'b1, 4);
        repeat (8) @(posedge clk);
        #1;
        chk("midstart_no_px", rx, 0);
        send_frame(8, 4, 2, 2, 1'b1, BIG, -1, 1'b1, 1'b1, 5);
        vsync_line();
        drain("midstart");
        chk("midstart_first", first_sof * 10000 + first_x * 100 + first_y, 10000);
        chk("midstart_count", rx, 32);
        chk("midstart_frame_done", fd_cnt - fd0, 1);

        // ---- short lines, ready toggling ----
        ready_mode = 2; exp_h = 4; exp_v = 3; rx = 0; fd0 = fd_cnt;
        send_frame(4, 3, 2, 2, 1'b1, BIG, -1, 1'b1, 1'b1, 6);
        vsync_line();
        drain("toggle");
        chk("toggle_count", rx, 12);
        chk("toggle_last_xy", last_x * 100 + last_y, 302);
        chk("toggle_frame_done", fd_cnt - fd0, 1);
        chk("toggle_overflow", overflow, 0);

        // ---- enable dropped mid-frame ----
        ready_mode = 1; exp_h = 6; exp_v = 4; rx = 0; fd0 = fd_cnt;
        send_frame(6, 4, 2, 2, 1'b1, BIG, 4, 1'b0, 1'b1, 7);
        send_frame(6, 4, 2, 2, 1'b0, 0, -1, 1'b0, 1'b1, 8);
        vsync_line();
        drain("endrop");
        chk("endrop_count", rx, 24);
        chk("endrop_frame_done", fd_cnt - fd0, 1);

        // ---- reset with 5 entries held ----
        enable = 1'b1; ready_mode = 0;
        repeat (3) @(posedge clk);
        #1;
        send_frame(5, 1, 2, 1, 1'b1, BIG, -1, 1'b1, 1'b1, 9);
        repeat (2) @(posedge clk);
        #1;
        chk("prerst_valid", pix_valid, 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_pix_valid", pix_valid, 0);
        chk("rst_pix_bus", longint'({pix_data, pix_x, pix_y, pix_sof, pix_sol}), 0);
        q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        ready_mode = 1; rx = 0; fd0 = fd_cnt;
        send_frame(5, 1, 2, 1, 1'b0, 0, -1, 1'b1, 1'b0, 10);
        repeat (10) @(posedge clk);
        #1;
        chk("postrst_no_px", rx, 0);
        exp_h = 5; exp_v = 1;
        send_frame(5, 1, 2, 1, 1'b1, BIG, -1, 1'b1, 1'b1, 11);
        vsync_line();
        drain("postrst");
        chk("postrst_count", rx, 5);
        chk("postrst_frame_done", fd_cnt - fd0, 1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
